// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the MEM/WB writeback stage
package wb_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                     regwrite;
    logic                     memtoreg;
    load_type_e               loadtype;
    logic [1:0]               byteoff;
    logic [WB_REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]     alu;
  } mem_wb_entry_t;

  // Halfwords need an even offset, words (and reserved encodings, which act as LW) a zero offset.
  function automatic logic is_misaligned(input load_type_e lt, input logic [1:0] off);
    logic r;
    case (lt)
      LT_LH, LT_LHU: r = off[0];
      LT_LB, LT_LBU: r = 1'b0;
      default:       r = (off != 2'd0);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_stage_load_formatter.sv
// rtl/wb_stage_load_formatter.sv - big-endian sub-word select and sign/zero extension for loads
module load_formatter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  load_type_e        i_load_type,
  input  logic [1:0]        i_byte_off,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword; offset 0 is the most significant lane.
  always_comb begin
    w_byte = i_word[DATA_W-25 -: 8];
    case (i_byte_off)
      2'd0:    w_byte = i_word[DATA_W-1  -: 8];
      2'd1:    w_byte = i_word[DATA_W-9  -: 8];
      2'd2:    w_byte = i_word[DATA_W-17 -: 8];
      default: w_byte = i_word[DATA_W-25 -: 8];
    endcase
    w_half = i_byte_off[1] ? i_word[DATA_W-17 -: 16] : i_word[DATA_W-1 -: 16];
  end

  // Extend the selected lane to full width; unknown encodings pass the word through like LW.
  always_comb begin
    o_data = i_word;
    case (i_load_type)
      LT_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LT_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
      LT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register and writeback formatter; optional WB_MISALIGN_CHECK_EN adds MisalignErr__o
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
  input  logic                  clock__i,
  input  logic                  rst__i,
  input  logic                  Valid__i,
  input  logic                  RegWrite__i,
  input  logic                  MemToReg__i,
  input  logic [2:0]            LoadType__i,
  input  logic [1:0]            ByteOff__i,
  input  logic [REG_ADDR_W-1:0] AddrRd__i,
  input  logic [DATA_W-1:0]     AluResult__i,
  input  logic [DATA_W-1:0]     MemRdata__i,
  input  logic                  MemRdValid__i,
  input  logic                  Flush__i,
  output logic                  Stall__o,
  output logic                  RegWrite__o,
  output logic [REG_ADDR_W-1:0] AddrRd__o,
  output logic [DATA_W-1:0]     DataRd__o
`ifdef WB_MISALIGN_CHECK_EN
  ,
  output logic                  MisalignErr__o
`endif
);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  mem_wb_entry_t         r_entry;
  mem_wb_entry_t         w_in_entry;
  mem_wb_entry_t         w_sel_entry;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_hold_load;
  logic                  w_wr_en;
  logic                  w_misalign;
  logic [DATA_W-1:0]     w_fmt;
  logic [DATA_W-1:0]     w_wdata;
  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_data;
`ifdef WB_MISALIGN_CHECK_EN
  logic                  r_misalign;
`endif

  assign w_accept = Valid__i & ~Flush__i;

  // Pack the incoming MEM entry so it can be parked while a load waits on memory.
  always_comb begin
    w_in_entry          = '0;
    w_in_entry.regwrite = RegWrite__i;
    w_in_entry.memtoreg = MemToReg__i;
    w_in_entry.loadtype = load_type_e'(LoadType__i);
    w_in_entry.byteoff  = ByteOff__i;
    w_in_entry.addr     = AddrRd__i;
    w_in_entry.alu      = AluResult__i;
  end

  // While waiting, the parked entry drives writeback; otherwise the live MEM entry does.
  assign w_sel_entry = (r_state == S_WAIT) ? r_entry : w_in_entry;

  load_formatter #(
    .DATA_W(DATA_W)
  ) u_load_formatter (
    .i_load_type(w_sel_entry.loadtype),
    .i_byte_off (w_sel_entry.byteoff),
    .i_word     (MemRdata__i),
    .o_data     (w_fmt)
  );

  // State register.
  always_ff @(posedge clock__i) begin
    if (rst__i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: enter WAIT on a load whose data has not arrived, leave on the response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && MemToReg__i && !MemRdValid__i) w_state_nxt = S_WAIT;
      S_WAIT:  if (MemRdValid__i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: stall while load data is outstanding, commit when the entry can retire.
  always_comb begin
    Stall__o    = 1'b0;
    w_commit    = 1'b0;
    w_hold_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (MemToReg__i && !MemRdValid__i) begin
            Stall__o    = 1'b1;
            w_hold_load = 1'b1;
          end else begin
            w_commit = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (MemRdValid__i) w_commit = 1'b1;
        else               Stall__o = 1'b1;
      end
      default: ;
    endcase
  end

  // Park the load entry for the duration of the wait.
  always_ff @(posedge clock__i) begin
    if (rst__i)           r_entry <= '0;
    else if (w_hold_load) r_entry <= w_in_entry;
  end

  // Writeback data and enable; loads always write, r0 and misaligned accesses never do.
  always_comb begin
    w_wdata = w_sel_entry.memtoreg ? w_fmt : w_sel_entry.alu;
`ifdef WB_MISALIGN_CHECK_EN
    w_misalign = w_sel_entry.memtoreg & is_misaligned(w_sel_entry.loadtype, w_sel_entry.byteoff);
`else
    w_misalign = 1'b0;
`endif
    w_wr_en = w_commit & (w_sel_entry.memtoreg | w_sel_entry.regwrite) &
              (w_sel_entry.addr != '0) & ~w_misalign;
  end

  // Registered register-file write port; address and data hold when nothing retires.
  always_ff @(posedge clock__i) begin
    if (rst__i) begin
      r_regwrite <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_regwrite <= w_wr_en;
      if (w_commit) begin
        r_addr <= w_sel_entry.addr;
        r_data <= w_wdata;
      end
    end
  end

`ifdef WB_MISALIGN_CHECK_EN
  // Misalignment flag pulses in the cycle the suppressed write would have appeared.
  always_ff @(posedge clock__i) begin
    if (rst__i) r_misalign <= 1'b0;
    else        r_misalign <= w_commit & w_misalign;
  end

  assign MisalignErr__o = r_misalign;
`endif

  assign RegWrite__o = r_regwrite;
  assign AddrRd__o   = r_addr;
  assign DataRd__o   = r_data;

endmodule
